mem_access_unit: RTL and testbench

Memory access stage of the LC-3b datapath, directly downstream of the address adder. Holds MAR and MDR, runs the memory handshake for load/store microstates, and provides the ready bit R that the control store loops on. It also performs byte-lane steering and sign-extension for byte accesses, and flags unaligned word accesses and memory timeouts.

---
 rtl/lc3b_mem_pkg.sv | 31 +++
 rtl/mdr_byte_select.sv | 42 ++++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_mem_pkg.sv
// Shared definitions for the LC-3b memory access stage.
// Contents: access FSM state type, DATA_SIZE / R_W encodings,
// byte-lane write-enable codes and the byte sign-extend helper
// that the datapath SEXT logic also uses.
package lc3b_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mau_state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_LO   = 2'b01;
    localparam logic [1:0] WE_HI   = 2'b10;
    localparam logic [1:0] WE_BOTH = 2'b11;

    // Width of the REQ-cycle timeout counter (TIMEOUT_CYCLES <= 255).
    localparam int unsigned CNT_W = 8;

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mdr_byte_select.sv
// Byte-lane steering for the memory access stage.
// Ports:
//   mdr        in  16  memory data register
//   mar_lsb    in  1   MAR[0], selects the high byte for byte accesses
//   size_sel   in  1   latched access size (SIZE_BYTE / SIZE_WORD)
//   rw         in  1   latched direction (RW_READ / RW_WRITE)
//   req_active in  1   high while the memory request is outstanding
//   mdr_bus    out 16  MDR value presented to GateMDR (byte-selected, sign-extended)
//   mem_we     out 2   byte-lane write enables
module mdr_byte_select
    import lc3b_mem_pkg::*;
(
    input  logic [15:0] mdr,
    input  logic        mar_lsb,
    input  logic        size_sel,
    input  logic        rw,
    input  logic        req_active,
    output logic [15:0] mdr_bus,
    output logic [1:0]  mem_we
);

    always_comb begin
        mdr_bus = mdr;
        if (size_sel == SIZE_BYTE) begin
            mdr_bus = mar_lsb ? sext8(mdr[15:8]) : sext8(mdr[7:0]);
        end
    end

    always_comb begin
        mem_we = WE_NONE;
        if (req_active && (rw == RW_WRITE)) begin
            if (size_sel == SIZE_WORD) begin
                mem_we = WE_BOTH;
            end else if (mar_lsb) begin
                mem_we = WE_HI;
            end else begin
                mem_we = WE_LO;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// LC-3b memory access stage: MAR/MDR registers, memory handshake FSM,
// ready bit R for the control store, unaligned-word and timeout flags.
// Ports:
//   CLK, RESET_N         clock, asynchronous active-low reset
//   ADDR, LD_MAR         effective address and MAR load
//   BUS, LD_MDR          datapath bus and MDR load (store data)
//   MIO_EN, R_W          start access, direction (0 read, 1 write)
//   DATA_SIZE            0 byte, 1 word
//   MEM_RDATA, MEM_READY memory read data and completion
//   MEM_ADDR, MEM_WDATA  memory address (MAR) and write data (MDR)
//   MEM_WE, MEM_REQ      byte-lane write enables and request
//   R, UNALIGNED, TIMEOUT one-cycle completion pulse and its qualifiers
//   MAR, MDR_BUS         MAR value and GateMDR value
module mem_access_unit
    import lc3b_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] ADDR,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic [15:0] BUS,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic        DATA_SIZE,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_READY,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic [1:0]  MEM_WE,
    output logic        MEM_REQ,
    output logic        R,
    output logic        UNALIGNED,
    output logic        TIMEOUT,
    output logic [15:0] MAR,
    output logic [15:0] MDR_BUS
);

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mau_state_t       state_q, state_d;
    logic [15:0]      mar_q, mar_d;
    logic [15:0]      mdr_q, mdr_d;
    logic             rw_q, rw_d;
    logic             size_q, size_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             r_q, unal_q, tmo_q;
    logic             unal_d, tmo_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            rw_q    <= RW_READ;
            size_q  <= SIZE_WORD;
            cnt_q   <= '0;
            r_q     <= 1'b0;
            unal_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            r_q     <= (state_d == DONE);
            unal_q  <= unal_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        unal_d  = 1'b0;
        tmo_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (LD_MAR) begin
                    mar_d = ADDR;
                end
                if (LD_MDR) begin
                    // Byte stores replicate the low byte so either lane carries it.
                    mdr_d = (DATA_SIZE == SIZE_WORD) ? BUS : {BUS[7:0], BUS[7:0]};
                end
                if (MIO_EN) begin
                    rw_d   = R_W;
                    size_d = DATA_SIZE;
                    cnt_d  = '0;
                    if ((DATA_SIZE == SIZE_WORD) && mar_q[0]) begin
                        state_d = DONE;
                        unal_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Ready wins over timeout in the final allowed cycle.
                if (MEM_READY) begin
                    state_d = DONE;
                    if (rw_q == RW_READ) begin
                        mdr_d = MEM_RDATA;
                    end
                end else if (cnt_q == TMO_LIMIT) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mdr_byte_select u_byte_select (
        .mdr        (mdr_q),
        .mar_lsb    (mar_q[0]),
        .size_sel   (size_q),
        .rw         (rw_q),
        .req_active (state_q == REQ),
        .mdr_bus    (MDR_BUS),
        .mem_we     (MEM_WE)
    );

    assign MEM_REQ   = (state_q == REQ);
    assign MEM_ADDR  = mar_q;
    assign MEM_WDATA = mdr_q;
    assign MAR       = mar_q;
    assign R         = r_q;
    assign UNALIGNED = unal_q;
    assign TIMEOUT   = tmo_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int T = 16;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] ADDR, BUS, MEM_RDATA;
    logic        LD_MAR, LD_MDR, MIO_EN, R_W, DATA_SIZE, MEM_READY;
    logic [15:0] MEM_ADDR, MEM_WDATA, MAR, MDR_BUS;
    logic [1:0]  MEM_WE;
    logic        MEM_REQ, R, UNALIGNED, TIMEOUT;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [15:0] m_mdr;

    always #5 CLK = ~CLK;

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .BUS(BUS), .MIO_EN(MIO_EN), .R_W(R_W), .DATA_SIZE(DATA_SIZE),
        .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ), .R(R),
        .UNALIGNED(UNALIGNED), .TIMEOUT(TIMEOUT), .MAR(MAR), .MDR_BUS(MDR_BUS)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Value GateMDR should show, from the architectural rules.
    function automatic logic [15:0] exp_bus(input logic [15:0] mdr, input logic [15:0] mar,
                                            input logic sz);
        int unsigned b;
        if (sz) return mdr;
        b = mar[0] ? (32'(mdr) / 256) : (32'(mdr) % 256);
        return (b >= 128) ? 16'(b + 65280) : 16'(b);
    endfunction

    // Drives one access and records what was observed; checks happen in the callers.
    task automatic run_access(
        input  logic [15:0] addr, input logic rw, input logic sz, input logic [15:0] bus,
        input  int ready_after, input logic [15:0] rdata, input logic disturb,
        output int req_cycles, output logic [1:0] we_seen, output logic [15:0] wdata_seen,
        output logic [15:0] addr_seen, output logic unal_seen, output logic tmo_seen,
        output int r_lat, output logic r_after);
        ADDR = addr; LD_MAR = 1'b1; BUS = bus; LD_MDR = rw; DATA_SIZE = sz;
        tick();
        LD_MAR = 1'b0; LD_MDR = 1'b0;
        MIO_EN = 1'b1; R_W = rw; DATA_SIZE = sz;
        tick();
        MIO_EN = 1'b0;
        req_cycles = 0; we_seen = 2'b00; wdata_seen = '0; addr_seen = '0;
        unal_seen = 1'b0; tmo_seen = 1'b0; r_lat = -1;
        for (int c = 1; c <= 300 && r_lat < 0; c++) begin
            if (MEM_REQ) begin
                req_cycles++;
                we_seen = MEM_WE; wdata_seen = MEM_WDATA; addr_seen = MEM_ADDR;
                if (disturb) begin
                    LD_MAR = 1'b1; ADDR = ~addr; LD_MDR = 1'b1; BUS = 16'($urandom);
                end
            end
            if (R) begin
                r_lat = c; unal_seen = UNALIGNED; tmo_seen = TIMEOUT;
            end else if (MEM_REQ && req_cycles == ready_after) begin
                MEM_READY = 1'b1; MEM_RDATA = rdata;
            end
            tick();
            MEM_READY = 1'b0; MEM_RDATA = 16'($urandom);
            LD_MAR = 1'b0; LD_MDR = 1'b0;
        end
        r_after = R;
    endtask

    int rc, lat;
    logic [1:0] we;
    logic [15:0] wd, ad;
    logic un, to, ra;

    task automatic test_reset();
        RESET_N = 1'b0;
        #2;
        n_checks++;
        if ({MEM_REQ, MEM_WE, R, UNALIGNED, TIMEOUT} !== 5'b0) begin
            n_errors++; $display("FAIL reset_ctrl got=%b exp=00000", {MEM_REQ, MEM_WE, R, UNALIGNED, TIMEOUT});
        end
        n_checks++;
        if (MAR !== 16'h0 || MDR_BUS !== 16'h0 || MEM_WDATA !== 16'h0) begin
            n_errors++; $display("FAIL reset_regs got MAR=%h MDR_BUS=%h WDATA=%h exp=0", MAR, MDR_BUS, MEM_WDATA);
        end
        tick(); tick();
        RESET_N = 1'b1;
        tick();
        m_mdr = 16'h0;
        n_checks++;
        if (R !== 1'b0 || MEM_REQ !== 1'b0) begin
            n_errors++; $display("FAIL reset_idle got R=%b REQ=%b exp=0 0", R, MEM_REQ);
        end
    endtask

    task automatic test_word_read();
        run_access(16'h3000, 1'b0, 1'b1, 16'h0, 3, 16'hBEEF, 1'b0, rc, we, wd, ad, un, to, lat, ra);
        m_mdr = 16'hBEEF;
        n_checks++;
        if (rc !== 3 || lat !== 4) begin
            n_errors++; $display("FAIL word_read_timing got req=%0d lat=%0d exp req=3 lat=4", rc, lat);
        end
        n_checks++;
        if (MDR_BUS !== 16'hBEEF || ad !== 16'h3000 || we !== 2'b00) begin
            n_errors++; $display("FAIL word_read_data got bus=%h addr=%h we=%b exp BEEF 3000 00", MDR_BUS, ad, we);
        end
        n_checks++;
        if (ra !== 1'b0 || un !== 1'b0 || to !== 1'b0) begin
            n_errors++; $display("FAIL word_read_pulse got r_after=%b un=%b to=%b exp 000", ra, un, to);
        end
    endtask

    task automatic test_byte_read();
        logic [15:0] addrs [3] = '{16'h3001, 16'h3000, 16'h3000};
        logic [15:0] datas [3] = '{16'h80FF, 16'h80FF, 16'h7F12};
        logic [15:0] exps  [3] = '{16'hFF80, 16'hFFFF, 16'h0012};
        for (int i = 0; i < 3; i++) begin
            run_access(addrs[i], 1'b0, 1'b0, 16'h0, 1, datas[i], 1'b0, rc, we, wd, ad, un, to, lat, ra);
            m_mdr = datas[i];
            n_checks++;
            if (MDR_BUS !== exps[i] || lat !== 2) begin
                n_errors++; $display("FAIL byte_read_%0d got bus=%h lat=%0d exp bus=%h lat=2", i, MDR_BUS, lat, exps[i]);
            end
        end
    endtask

    task automatic test_write();
        run_access(16'h4001, 1'b1, 1'b0, 16'h1234, 2, 16'h0, 1'b0, rc, we, wd, ad, un, to, lat, ra);
        m_mdr = 16'h3434;
        n_checks++;
        if (wd !== 16'h3434 || we !== 2'b10 || lat !== 3) begin
            n_errors++; $display("FAIL byte_write got wdata=%h we=%b lat=%0d exp 3434 10 3", wd, we, lat);
        end
        run_access(16'h4000, 1'b1, 1'b0, 16'h5678, 1, 16'hFFFF, 1'b0, rc, we, wd, ad, un, to, lat, ra);
        m_mdr = 16'h7878;
        n_checks++;
        if (wd !== 16'h7878 || we !== 2'b01 || MDR_BUS !== 16'h0078) begin
            n_errors++; $display("FAIL byte_write_even got wdata=%h we=%b bus=%h exp 7878 01 0078", wd, we, MDR_BUS);
        end
        run_access(16'h4000, 1'b1, 1'b1, 16'h1234, 1, 16'hFFFF, 1'b0, rc, we, wd, ad, un, to, lat, ra);
        m_mdr = 16'h1234;
        n_checks++;
        if (wd !== 16'h1234 || we !== 2'b11 || MDR_BUS !== 16'h1234) begin
            n_errors++; $display("FAIL word_write got wdata=%h we=%b bus=%h exp 1234 11 1234", wd, we, MDR_BUS);
        end
    endtask

    task automatic test_unaligned();
        run_access(16'h4003, 1'b0, 1'b1, 16'h0, 1, 16'hDEAD, 1'b0, rc, we, wd, ad, un, to, lat, ra);
        n_checks++;
        if (lat !== 1 || un !== 1'b1 || to !== 1'b0 || rc !== 0) begin
            n_errors++; $display("FAIL unaligned got lat=%0d un=%b to=%b req=%0d exp 1 1 0 0", lat, un, to, rc);
        end
        n_checks++;
        if (MDR_BUS !== m_mdr || ra !== 1'b0) begin
            n_errors++; $display("FAIL unaligned_mdr got bus=%h r_after=%b exp %h 0", MDR_BUS, ra, m_mdr);
        end
    endtask

    task automatic test_timeout();
        run_access(16'h5000, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b1, rc, we, wd, ad, un, to, lat, ra);
        n_checks++;
        if (rc !== T + 1 || lat !== T + 2 || to !== 1'b1 || un !== 1'b0) begin
            n_errors++; $display("FAIL timeout got req=%0d lat=%0d to=%b un=%b exp %0d %0d 1 0", rc, lat, to, un, T + 1, T + 2);
        end
        n_checks++;
        if (MAR !== 16'h5000 || MDR_BUS !== m_mdr || ra !== 1'b0) begin
            n_errors++; $display("FAIL timeout_regs got MAR=%h bus=%h r_after=%b exp 5000 %h 0", MAR, MDR_BUS, ra, m_mdr);
        end
    endtask

    task automatic test_random();
        logic [15:0] addr, bus, rdata, e_wd;
        logic rw, sz, unal, ok;
        int rdy, e_lat, e_rc;
        logic [1:0] e_we;
        for (int i = 0; i < 40; i++) begin
            addr = 16'($urandom); bus = 16'($urandom); rdata = 16'($urandom);
            rw = 1'($urandom); sz = 1'($urandom);
            rdy = int'($urandom_range(0, T + 3));
            run_access(addr, rw, sz, bus, rdy, rdata, 1'($urandom), rc, we, wd, ad, un, to, lat, ra);
            unal = sz && addr[0];
            ok = !unal && rdy >= 1 && rdy <= T + 1;
            e_lat = unal ? 1 : (ok ? rdy + 1 : T + 2);
            e_rc = unal ? 0 : (ok ? rdy : T + 1);
            if (rw) m_mdr = sz ? bus : 16'((32'(bus) % 256) * 257);
            e_wd = unal ? 16'h0 : m_mdr;
            e_we = (unal || !rw) ? 2'b00 : (sz ? 2'b11 : (addr[0] ? 2'b10 : 2'b01));
            if (!rw && ok) m_mdr = rdata;
            n_checks++;
            if (lat !== e_lat || rc !== e_rc || un !== unal || to !== (!unal && !ok) || ra !== 1'b0) begin
                n_errors++;
                $display("FAIL rand_%0d_ctrl got lat=%0d req=%0d un=%b to=%b ra=%b exp lat=%0d req=%0d un=%b to=%b ra=0",
                         i, lat, rc, un, to, ra, e_lat, e_rc, unal, !unal && !ok);
            end
            n_checks++;
            if (we !== e_we || wd !== e_wd || (!unal && ad !== addr) || MAR !== addr) begin
                n_errors++;
                $display("FAIL rand_%0d_mem got we=%b wdata=%h addr=%h MAR=%h exp we=%b wdata=%h addr=%h",
                         i, we, wd, ad, MAR, e_we, e_wd, addr);
            end
            n_checks++;
            if (MDR_BUS !== exp_bus(m_mdr, addr, sz) || MEM_WDATA !== m_mdr) begin
                n_errors++;
                $display("FAIL rand_%0d_mdr got bus=%h wdata=%h exp bus=%h mdr=%h",
                         i, MDR_BUS, MEM_WDATA, exp_bus(m_mdr, addr, sz), m_mdr);
            end
        end
    endtask

    task automatic test_async_reset();
        ADDR = 16'h6001; LD_MAR = 1'b1; BUS = 16'hA5C3; LD_MDR = 1'b1; DATA_SIZE = 1'b0;
        tick();
        LD_MAR = 1'b0; LD_MDR = 1'b0;
        MIO_EN = 1'b1; R_W = 1'b1;
        tick();
        MIO_EN = 1'b0;
        tick(); tick();
        n_checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 2'b10) begin
            n_errors++; $display("FAIL areset_pre got req=%b we=%b exp 1 10", MEM_REQ, MEM_WE);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_checks++;
        if (MEM_REQ !== 1'b0 || MEM_WE !== 2'b00 || R !== 1'b0) begin
            n_errors++; $display("FAIL areset_async got req=%b we=%b R=%b exp 0 00 0", MEM_REQ, MEM_WE, R);
        end
        tick();
        RESET_N = 1'b1;
        tick();
        m_mdr = 16'h0;
        n_checks++;
        if (MAR !== 16'h0 || MDR_BUS !== 16'h0 || R !== 1'b0 || MEM_REQ !== 1'b0) begin
            n_errors++; $display("FAIL areset_post got MAR=%h bus=%h R=%b req=%b exp 0 0 0 0", MAR, MDR_BUS, R, MEM_REQ);
        end
    endtask

    initial begin
        ADDR = '0; BUS = '0; MEM_RDATA = '0; LD_MAR = 1'b0; LD_MDR = 1'b0;
        MIO_EN = 1'b0; R_W = 1'b0; DATA_SIZE = 1'b1; MEM_READY = 1'b0;
        m_mdr = '0;
        test_reset();
        test_word_read();
        test_byte_read();
        test_write();
        test_unaligned();
        test_timeout();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
